// File: rtl/multiword_addsub_seq.sv
// Multi-precision add/subtract sequencer built around one 32-bit Kogge-Stone adder.
// Operands are processed one 32-bit word per cycle, least significant word first.
// The carry between words is held in a register.

// 32-bit parallel-prefix adder with carry-in and carry-out.
module kogge_stone_adder_32bits (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] gn;
   logic [31:0] pn;
   logic [31:0] c;

   // Prefix tree over generate/propagate pairs.
   // Spans double each level: 1, 2, 4, 8, 16.
   // cin is folded in when the per-bit carries are formed.
   always_comb begin
      g  = a & b;
      p  = a ^ b;
      gn = '0;
      pn = '0;
      for (int unsigned d = 1; d < 32; d = d * 2) begin
         gn = g;
         pn = p;
         for (int unsigned i = d; i < 32; i++) begin
            gn[i] = g[i] | (p[i] & g[i-d]);
            pn[i] = p[i] & p[i-d];
         end
         g = gn;
         p = pn;
      end
      c    = {g[30:0] | (p[30:0] & {31{cin}}), cin};
      sum  = (a ^ b) ^ c;
      cout = g[31] | (p[31] & cin);
   end

endmodule

// Sequencer: IDLE accepts a request, RUN walks the words, DONE holds the result until it is accepted.
module multiword_addsub_seq #(
   parameter int NUM_WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   op_sub,
   input  logic                   cin,
   input  logic [NUM_WORDS*32-1:0] operand_a,
   input  logic [NUM_WORDS*32-1:0] operand_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM_WORDS*32-1:0] result,
   output logic                   cout,
   output logic                   overflow
);

   localparam int W     = NUM_WORDS * 32;
   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [W-1:0]     a_reg;
   logic [W-1:0]     b_reg;
   logic             carry;
   logic [IDX_W-1:0] idx;
   logic [31:0]      word_sum;
   logic             word_cout;
   logic             last;

   assign last = (idx == IDX_W'(NUM_WORDS - 1));

   kogge_stone_adder_32bits u_adder (
      .a    (a_reg[{idx, 5'b0} +: 32]),
      .b    (b_reg[{idx, 5'b0} +: 32]),
      .cin  (carry),
      .sum  (word_sum),
      .cout (word_cout)
   );

   // Control FSM and datapath registers; all outputs are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
         idx       <= '0;
         carry     <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is stored as A + ~B with the carry preset to 1.
                  a_reg    <= operand_a;
                  b_reg    <= op_sub ? ~operand_b : operand_b;
                  carry    <= op_sub ? 1'b1 : cin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               result[{idx, 5'b0} +: 32] <= word_sum;
               carry                     <= word_cout;
               if (last) begin
                  idx       <= '0;
                  out_valid <= 1'b1;
                  cout      <= word_cout;
                  overflow  <= (a_reg[W-1] == b_reg[W-1]) && (word_sum[31] != a_reg[W-1]);
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Directed testbench for multiword_addsub_seq with NUM_WORDS=4.
module tb_multiword_addsub_seq;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic         cin;
   logic [127:0] operand_a;
   logic [127:0] operand_b;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] result;
   logic         cout;
   logic         overflow;

   int checks   = 0;
   int failures = 0;

   multiword_addsub_seq #(.NUM_WORDS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .cin       (cin),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request, then check the latency, the result and the handshake back to IDLE.
   task automatic run_op(input string tag, input logic sub, input logic ci,
                         input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] r, input logic co, input logic ov);
      int lat;
      op_sub    = sub;
      cin       = ci;
      operand_a = a;
      operand_b = b;
      in_valid  = 1'b1;
      tick;
      in_valid  = 1'b0;
      operand_a = '1;
      operand_b = '1;
      cin       = ~ci;
      op_sub    = ~sub;
      chk({tag, "_busy"}, 128'(in_ready), 128'(1'b0));
      lat = 1;
      tick;
      while (!out_valid && lat < 20) begin
         tick;
         lat++;
      end
      chk({tag, "_latency"}, 128'(lat), 128'(4));
      chk({tag, "_result"}, result, r);
      chk({tag, "_cout"}, 128'(cout), 128'(co));
      chk({tag, "_ovf"}, 128'(overflow), 128'(ov));
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk({tag, "_ack_valid"}, 128'(out_valid), 128'(1'b0));
      chk({tag, "_ack_ready"}, 128'(in_ready), 128'(1'b1));
   endtask

   logic [127:0] ta [3];
   logic [127:0] tb [3];
   logic         tsub [3];
   logic         tcin [3];
   logic [127:0] er [3];
   logic         ec [3];
   logic         eo [3];
   logic [128:0] full;
   logic [127:0] beff;

   initial begin
      int k_acc;
      int k_done;
      int last_acc;
      int cyc;
      logic acc;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_sub    = 1'b0;
      cin       = 1'b0;
      operand_a = '0;
      operand_b = '0;
      tick;
      tick;
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_result", result, 128'(0));
      chk("rst_cout", 128'(cout), 128'(1'b0));
      chk("rst_ovf", 128'(overflow), 128'(1'b0));
      rst = 1'b0;
      tick;

      // T1..T3 plus extra carry, borrow and overflow corners
      run_op("t1_add_wrap", 1'b0, 1'b0, {128{1'b1}}, 128'd1, 128'd0, 1'b1, 1'b0);
      run_op("t2_sub_neg", 1'b1, 1'b0, 128'd5, 128'd7,
             128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      run_op("t3_add_ovf", 1'b0, 1'b0, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
             128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
      run_op("add_cin_chain", 1'b0, 1'b1, 128'hFFFF_FFFF, 128'd0,
             128'h1_0000_0000, 1'b0, 1'b0);
      run_op("sub_pos", 1'b1, 1'b0, 128'd7, 128'd5, 128'd2, 1'b1, 1'b0);
      run_op("sub_cin_ignored", 1'b1, 1'b1, 128'd5, 128'd5, 128'd0, 1'b1, 1'b0);
      run_op("sub_ovf", 1'b1, 1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1,
             128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

      // T4: stall the consumer while a second request waits
      op_sub    = 1'b0;
      cin       = 1'b0;
      operand_a = 128'd1;
      operand_b = 128'd2;
      in_valid  = 1'b1;
      tick;
      operand_a = 128'd10;
      operand_b = 128'd20;
      cin       = 1'b1;
      tick;
      tick;
      tick;
      tick;
      chk("t4_valid_rise", 128'(out_valid), 128'(1'b1));
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("t4_hold_valid", 128'(out_valid), 128'(1'b1));
         chk("t4_hold_ready", 128'(in_ready), 128'(1'b0));
         chk("t4_hold_result", result, 128'd3);
         chk("t4_hold_cout", 128'(cout), 128'(1'b0));
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("t4_ack_ready", 128'(in_ready), 128'(1'b1));
      chk("t4_ack_valid", 128'(out_valid), 128'(1'b0));
      tick;
      in_valid = 1'b0;
      chk("t4_second_accepted", 128'(in_ready), 128'(1'b0));
      tick;
      tick;
      tick;
      tick;
      chk("t4_second_valid", 128'(out_valid), 128'(1'b1));
      chk("t4_second_result", result, 128'd31);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;

      // T5: reset while the third word is being processed
      operand_a = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
      operand_b = 128'h1;
      op_sub    = 1'b0;
      cin       = 1'b0;
      in_valid  = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("t5_in_ready", 128'(in_ready), 128'(1'b1));
      chk("t5_out_valid", 128'(out_valid), 128'(1'b0));
      chk("t5_result", result, 128'd0);
      tick;
      tick;
      tick;
      chk("t5_no_partial", 128'(out_valid), 128'(1'b0));

      // T6: back-to-back random operations against a reference model
      for (int k = 0; k < 3; k++) begin
         ta[k]   = {$urandom, $urandom, $urandom, $urandom};
         tb[k]   = {$urandom, $urandom, $urandom, $urandom};
         tsub[k] = 1'(k == 1);
         tcin[k] = 1'(k == 2);
         beff    = tsub[k] ? ~tb[k] : tb[k];
         full    = {1'b0, ta[k]} + {1'b0, beff} + 129'(tsub[k] ? 1'b1 : tcin[k]);
         er[k]   = full[127:0];
         ec[k]   = full[128];
         eo[k]   = (ta[k][127] == beff[127]) && (full[127] != ta[k][127]);
      end
      k_acc     = 0;
      k_done    = 0;
      last_acc  = 0;
      cyc       = 0;
      operand_a = ta[0];
      operand_b = tb[0];
      op_sub    = tsub[0];
      cin       = tcin[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (k_done < 3 && cyc < 100) begin
         acc = in_ready && in_valid;
         tick;
         cyc++;
         if (acc) begin
            if (k_acc > 0) chk("t6_interval", 128'(cyc - last_acc), 128'(6));
            last_acc = cyc;
            k_acc++;
            if (k_acc < 3) begin
               operand_a = ta[k_acc];
               operand_b = tb[k_acc];
               op_sub    = tsub[k_acc];
               cin       = tcin[k_acc];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            chk("t6_result", result, er[k_done]);
            chk("t6_cout", 128'(cout), 128'(ec[k_done]));
            chk("t6_ovf", 128'(overflow), 128'(eo[k_done]));
            k_done++;
         end
      end
      chk("t6_completed", 128'(k_done), 128'(3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
